// File: rtl/fb_mem_arbiter.sv
// Framebuffer RAM arbiter: scanout (client 0) has fixed priority, host (1) and draw (2)
// alternate round-robin. Registers the RAM command and steers read data back by tag.
module fb_mem_arbiter #(
  parameter int ADDR_WIDTH   = 17,
  parameter int DATA_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                  gpu_clk,
  input  logic                  reset,
  input  logic                  c0_req,
  input  logic                  c1_req,
  input  logic                  c2_req,
  input  logic                  c0_we,
  input  logic                  c1_we,
  input  logic                  c2_we,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [ADDR_WIDTH-1:0] c2_addr,
  input  logic [DATA_WIDTH-1:0] c0_wdata,
  input  logic [DATA_WIDTH-1:0] c1_wdata,
  input  logic [DATA_WIDTH-1:0] c2_wdata,
  output logic                  c0_gnt,
  output logic                  c1_gnt,
  output logic                  c2_gnt,
  output logic                  c0_rvalid,
  output logic                  c1_rvalid,
  output logic                  c2_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int TAG_DEPTH = READ_LATENCY + 1;

  // Handshake: a client raises cN_req with stable fields and keeps them until cN_gnt is
  // seen high in the same cycle; the access is taken on that rising edge. rvalid has no
  // backpressure and must be consumed the cycle it pulses.

  logic [2:0]            w_gnt;
  logic                  w_any_gnt;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [1:0]            w_sel_id;
  logic [2:0]            w_push_tag;
  logic [2:0]            w_exit_tag;

  logic                        r_rr_last_c2;
  logic [TAG_DEPTH-1:0][2:0]   r_tag;
  logic                        r_ram_en;
  logic                        r_ram_we;
  logic [ADDR_WIDTH-1:0]       r_ram_addr;
  logic [DATA_WIDTH-1:0]       r_ram_wdata;
  logic [DATA_WIDTH-1:0]       r_rdata;
  logic [2:0]                  r_rvalid;

  always_comb begin
    w_gnt = 3'b000;
    if (!reset) begin
      if (c0_req)                w_gnt = 3'b001;
      else if (c1_req && c2_req) w_gnt = r_rr_last_c2 ? 3'b010 : 3'b100;
      else if (c1_req)           w_gnt = 3'b010;
      else if (c2_req)           w_gnt = 3'b100;
    end
  end

  assign w_any_gnt = |w_gnt;

  always_comb begin
    w_sel_we    = c0_we;
    w_sel_addr  = c0_addr;
    w_sel_wdata = c0_wdata;
    w_sel_id    = 2'd0;
    if (w_gnt[1]) begin
      w_sel_we    = c1_we;
      w_sel_addr  = c1_addr;
      w_sel_wdata = c1_wdata;
      w_sel_id    = 2'd1;
    end else if (w_gnt[2]) begin
      w_sel_we    = c2_we;
      w_sel_addr  = c2_addr;
      w_sel_wdata = c2_wdata;
      w_sel_id    = 2'd2;
    end
  end

  // Tag = {valid, client id}; writes and idle cycles push an invalid tag.
  assign w_push_tag = {w_any_gnt && !w_sel_we, w_sel_id};
  assign w_exit_tag = r_tag[READ_LATENCY];

  always_ff @(posedge gpu_clk) begin
    if (reset)            r_rr_last_c2 <= 1'b1;
    else if (w_gnt[1])    r_rr_last_c2 <= 1'b0;
    else if (w_gnt[2])    r_rr_last_c2 <= 1'b1;
  end

  always_ff @(posedge gpu_clk) begin
    if (reset) begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_ram_en <= w_any_gnt;
      if (w_any_gnt) begin
        r_ram_we    <= w_sel_we;
        r_ram_addr  <= w_sel_addr;
        r_ram_wdata <= w_sel_wdata;
      end else begin
        r_ram_we <= 1'b0;
      end
    end
  end

  always_ff @(posedge gpu_clk) begin
    if (reset) r_tag <= '0;
    else       r_tag <= {r_tag[TAG_DEPTH-2:0], w_push_tag};
  end

  always_ff @(posedge gpu_clk) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rvalid <= 3'b000;
    end else begin
      r_rvalid <= 3'b000;
      if (w_exit_tag[2]) begin
        r_rdata  <= ram_rdata;
        r_rvalid <= 3'b001 << w_exit_tag[1:0];
      end
    end
  end

  assign c0_gnt    = w_gnt[0];
  assign c1_gnt    = w_gnt[1];
  assign c2_gnt    = w_gnt[2];
  assign c0_rvalid = r_rvalid[0];
  assign c1_rvalid = r_rvalid[1];
  assign c2_rvalid = r_rvalid[2];
  assign rdata     = r_rdata;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;

endmodule
